// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core datapath
// and the data-memory responder.
interface data_mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemError;

  modport master (
    output MemReq, MemWrite, Addr,
    output WriteData, Funct3,
    input  ReadData, MemReady, MemError
  );

  modport slave (
    input  MemReq, MemWrite, Addr,
    input  WriteData, Funct3,
    output ReadData, MemReady, MemError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: RV32I byte/half/word
// access with wait states and error reporting.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];

  logic            f3_ok, misal, oor, illegal;
  logic [AW-1:0]   widx;
  logic [31:0]     mem_rd, rd_sh;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_val;
  logic [3:0]      be;
  logic [31:0]     wr_lanes;
  logic            do_access;

  // Classify the request currently on the bus
  always_comb begin
    if (bus.MemWrite)
      f3_ok = bus.Funct3 inside
        {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.Funct3 inside
        {3'b000, 3'b001, 3'b010,
         3'b100, 3'b101};
    misal =
      (bus.Funct3[1:0] == 2'b01 && bus.Addr[0]) ||
      (bus.Funct3[1:0] == 2'b10 &&
       bus.Addr[1:0] != 2'b00);
    oor = {2'b00, bus.Addr[31:2]} >= 32'(DEPTH);
    illegal = !f3_ok || misal || oor;
  end

  // Lane extraction and load extension
  always_comb begin
    widx   = addr_q[AW+1:2];
    mem_rd = mem_q[widx];
    rd_sh  = mem_rd >> {addr_q[1:0], 3'b000};
    ld_b   = rd_sh[7:0];
    ld_h   = addr_q[1] ? mem_rd[31:16]
                       : mem_rd[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_val = mem_rd;
      3'b100:  ld_val = {24'h0, ld_b};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = rdata_q;
    endcase
  end

  // Store byte enables and lane-replicated data
  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100
                             : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state: capture, wait, access, respond
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MemReq) begin
          we_d    = bus.MemWrite;
          addr_d  = bus.Addr[AW+1:0];
          wdata_d = bus.WriteData;
          f3_d    = bus.Funct3;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CW'(WAIT_CYCLES);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          do_access = 1'b1;
          state_d   = DONE;
          if (!we_q) rdata_d = ld_val;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && do_access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem_q[widx][8*i +: 8] <=
            wr_lanes[8*i +: 8];
      end
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = (state_q == DONE);
  assign bus.MemError = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder:
// byte-array reference model, random + directed.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int W1    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  data_mem_responder_if b1 ();
  data_mem_responder_if b2 ();

  data_mem_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(W1)
  ) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
  );

  data_mem_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(0)
  ) dut2 (
    .clk(clk), .reset(rst2), .bus(b2.slave)
  );

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  mm [4*DEPTH];
  logic [31:0] rd_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Monitor for dut1
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e1 = q1.pop_front();
      checks++;
      errors++;
      $display("FAIL dut1_missing_ready: none by cycle %0d expected at %0d",
               cyc, e1.cyc);
    end
    if (b1.MemReady) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_ready: pulse at cycle %0d expected none",
                 cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_ready_cycle", cyc, e1.cyc);
        chk("dut1_error", 32'(b1.MemError),
            32'(e1.err));
        chk("dut1_rdata", b1.ReadData, e1.rd);
      end
    end
  end

  // Monitor for dut2
  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].cyc < cyc) begin
      e2 = q2.pop_front();
      checks++;
      errors++;
      $display("FAIL dut2_missing_ready: none by cycle %0d expected at %0d",
               cyc, e2.cyc);
    end
    if (b2.MemReady) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_ready: pulse at cycle %0d expected none",
                 cyc);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_ready_cycle", cyc, e2.cyc);
        chk("dut2_error", 32'(b2.MemError),
            32'(e2.err));
        chk("dut2_rdata", b2.ReadData, e2.rd);
      end
    end
  end

  function automatic bit bad_req(
    bit we, logic [31:0] a, logic [2:0] f3);
    bit ok;
    int n;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) ||
                 (f3 == 3'd5);
    if (!ok) return 1'b1;
    n = 1 << f3[1:0];
    if ((a % n) != 0) return 1'b1;
    if (a >= 32'(4*DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue1(bit we,
                        logic [31:0] a,
                        logic [31:0] wd,
                        logic [2:0] f3);
    exp_t   e;
    int     n;
    longint v;
    @(negedge clk);
    b1.MemReq    = 1'b1;
    b1.MemWrite  = we;
    b1.Addr      = a;
    b1.WriteData = wd;
    b1.Funct3    = f3;
    e.cyc = cyc;
    if (bad_req(we, a, f3)) begin
      e.cyc += 1;
      e.err = 1'b1;
    end else begin
      n = 1 << f3[1:0];
      e.cyc += W1 + 2;
      e.err = 1'b0;
      if (we) begin
        for (int i = 0; i < n; i++)
          mm[a + i] = 8'(wd >> (8*i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v += longint'(mm[a + i]) << (8*i);
        if (!f3[2] && n < 4 &&
            v >= (longint'(1) << (8*n - 1)))
          v -= longint'(1) << (8*n);
        rd_m = 32'(v);
      end
    end
    e.rd = rd_m;
    q1.push_back(e);
    @(negedge clk);
    b1.MemReq = 1'b0;
    if (!e.err) repeat (W1 + 1) @(negedge clk);
  endtask

  task automatic seq1();
    int lf [5] = '{0, 1, 2, 4, 5};
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rdata", b1.ReadData, 32'h0);
    chk("reset_ready", 32'(b1.MemReady), 32'h0);
    chk("reset_error", 32'(b1.MemError), 32'h0);
    rst1 = 1'b0;
    for (int w = 0; w < DEPTH; w++)
      issue1(1'b1, 32'(4*w), 32'h0, 3'b010);
    issue1(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    issue1(1'b0, 32'h10, 32'h0, 3'b010);
    issue1(1'b1, 32'h13, 32'h80, 3'b000);
    issue1(1'b0, 32'h13, 32'h0, 3'b000);
    issue1(1'b0, 32'h13, 32'h0, 3'b100);
    issue1(1'b0, 32'h10, 32'h0, 3'b010);
    issue1(1'b0, 32'h12, 32'h0, 3'b101);
    issue1(1'b0, 32'h12, 32'h0, 3'b010);
    issue1(1'b1, 32'h11, 32'hFFFF, 3'b001);
    issue1(1'b0, 32'h10, 32'h0, 3'b010);
    issue1(1'b0, 32'h400, 32'h0, 3'b010);
    issue1(1'b0, 32'h10, 32'h0, 3'b011);
    issue1(1'b1, 32'h10, 32'h1234, 3'b100);
    issue1(1'b0, 32'h10, 32'h0, 3'b010);
    // store aborted by reset while waiting
    @(negedge clk);
    b1.MemReq    = 1'b1;
    b1.MemWrite  = 1'b1;
    b1.Addr      = 32'h20;
    b1.WriteData = 32'h12345678;
    b1.Funct3    = 3'b010;
    @(negedge clk);
    b1.MemReq = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    rd_m = '0;
    chk("abort_rdata", b1.ReadData, 32'h0);
    chk("abort_ready", 32'(b1.MemReady), 32'h0);
    chk("abort_error", 32'(b1.MemError), 32'h0);
    repeat (W1 + 3) @(negedge clk);
    issue1(1'b0, 32'h20, 32'h0, 3'b010);
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        f3 = 3'($urandom_range(0, 7));
      else if (we)
        f3 = 3'($urandom_range(0, 2));
      else
        f3 = 3'(lf[$urandom_range(0, 4)]);
      a = 32'($urandom_range(0, 4*DEPTH + 15));
      if ($urandom_range(0, 1) == 1)
        a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      issue1(we, a, $urandom, f3);
    end
  endtask

  task automatic seq2();
    int c;
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    b2.MemReq    = 1'b1;
    b2.MemWrite  = 1'b1;
    b2.Addr      = 32'h10;
    b2.WriteData = 32'h80ADBEEF;
    b2.Funct3    = 3'b010;
    q2.push_back('{cyc + 2, 1'b0, 32'h0});
    @(negedge clk);
    b2.MemReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b2.MemReq   = 1'b1;
    b2.MemWrite = 1'b0;
    b2.Addr     = 32'h10;
    b2.Funct3   = 3'b010;
    c = cyc;
    for (int k = 0; k < 4; k++)
      q2.push_back('{c + 3*k + 2, 1'b0,
                     32'h80ADBEEF});
    repeat (12) @(negedge clk);
    b2.MemReq = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst1 = 1'b1;
    rst2 = 1'b1;
    b1.MemReq = 1'b0; b1.MemWrite = 1'b0;
    b1.Addr = '0; b1.WriteData = '0;
    b1.Funct3 = '0;
    b2.MemReq = 1'b0; b2.MemWrite = 1'b0;
    b2.Addr = '0; b2.WriteData = '0;
    b2.Funct3 = '0;
    fork
      seq1();
      seq2();
    join
    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RISC-V core: the slave end of the load/store interface that the datapath drives with ALUResult as the address and WriteData as the store data. The block adds a request/ready handshake with a configurable wait-state count, so the core can be tested against non-zero-latency memory. It handles RV32I byte, halfword and word accesses with little-endian lane placement, load sign/zero extension, and error reporting for misaligned, out-of-range and illegal-size accesses.

## Interface
- DEPTH, 256: number of 32-bit words; the legal byte address range is 0 to 4*DEPTH-1.
- WAIT_CYCLES, 2: number of wait states inserted before the access is performed (0 or more).

- clk  input  1  system clock; every action happens on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemReq  input  1  access request; sampled only in IDLE.
- MemWrite  input  1  1 = store, 0 = load.
- Addr  input  32  byte address (the datapath's ALUResult).
- WriteData  input  32  store data; the lowest byte or halfword is used for narrow stores.
- Funct3  input  3  access size and sign, RV32I encoding.
- ReadData  output  32  load result; registered.
- MemReady  output  1  one-cycle completion pulse.
- MemError  output  1  error flag; valid only while MemReady=1.

## Operation
- States: IDLE, BUSY, DONE. A down-counter cnt tracks the wait states.
- **IDLE**, MemReq=1 at an edge:
  - Capture MemWrite, Addr, WriteData and Funct3.
  - If the request is illegal, go to DONE with the error flag set.
  - Otherwise go to BUSY with cnt=WAIT_CYCLES.
- **Illegal** means any of:
  - Funct3 not in {000, 001, 010, 100, 101} for a load.
  - Funct3 not in {000, 001, 010} for a store.
  - A halfword access with Addr[0]=1.
  - A word access with Addr[1:0]≠0.
  - Addr[31:2] ≥ DEPTH.
- **BUSY**:
  - If cnt≠0, decrement cnt.
  - If cnt=0, perform the access at this edge and go to DONE.
- **DONE**: MemReady=1 for this one cycle. MemError is 1 only on the error path. Next state is IDLE.
- **Store**: write only the addressed byte lanes.
  - SB writes lane Addr[1:0].
  - SH writes lanes Addr[1]*2 and Addr[1]*2+1.
  - SW writes all four lanes.
  - ReadData is unchanged.
- **Load**: ReadData ← selected lanes.
  - LB and LH are sign-extended.
  - LBU and LHU are zero-extended.
  - LW takes the whole word.
- **Error path**: no memory write, and ReadData is unchanged.
- MemReq, Addr and the other request inputs are ignored in BUSY and DONE.
  - A request still held high in DONE is captured again in the next IDLE cycle.
  - The requester must drop MemReq in the cycle after it sees MemReady unless it wants a new access.
- **Reset**:
  - State ← IDLE, cnt ← 0, ReadData ← 0, MemReady ← 0, MemError ← 0.
  - Memory contents are not cleared.
  - Reset takes priority over everything else: reset asserted on the access edge suppresses the write.
  - Reset in BUSY or DONE aborts the access, and no MemReady pulse follows.

## Timing
- Cycle 0 is the cycle in which MemReq is high while the block is in IDLE.
- Legal access: MemReady=1 in cycle WAIT_CYCLES+2 only.
  - WAIT_CYCLES=0 gives cycle 2; WAIT_CYCLES=2 gives cycle 4.
- Illegal access: MemReady=1 and MemError=1 in cycle 1.
- ReadData is valid from the MemReady cycle and holds until the next successful load completes.
- Minimum spacing between captured requests is WAIT_CYCLES+3 cycles (legal) or 2 cycles (illegal).
- Memory array: the write is synchronous; the read is taken combinationally from the array and registered into ReadData at the access edge.

## Test plan
- **SW then LW**, WAIT_CYCLES=2: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - The store gives a MemReady pulse exactly in cycle 4, with MemError=0.
  - The load returns ReadData=0xDEADBEEF in its MemReady cycle.
- **Narrow accesses** after the previous test: SB 0x80 to 0x13, then LB 0x13, LBU 0x13, LW 0x10 and LHU 0x12.
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LW → 0x80ADBEEF.
  - LHU 0x12 → 0x000080AD.
- **Misaligned and illegal requests**:
  - LW 0x12 and SH 0x11 each give MemReady=MemError=1 in cycle 1.
  - A following LW 0x10 still returns 0x80ADBEEF.
  - ReadData is unchanged across the errors.
- **Out-of-range and illegal Funct3**, DEPTH=256:
  - LW 0x400 → error.
  - Load with Funct3=011 → error.
  - Store with Funct3=100 → error.
  - No memory word changes in any case.
- **Reset mid-access**: SW 0x12345678 to 0x20 (previously holding 0), reset pulsed for one cycle during BUSY.
  - No MemReady pulse follows.
  - All outputs read 0 after reset.
  - LW 0x20 returns 0x00000000.
- **Held request and WAIT_CYCLES=0**: MemReq held high continuously with LW 0x10.
  - MemReady pulses in cycle 2, then every 3 cycles.
  - Each pulse returns 0x80ADBEEF.
